// File: rtl/rv32i_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: state encoding,
// opcode constants, branch funct3 codes and the datapath mux/ALU select codes.
// Latency: n/a (definitions only). Backpressure: n/a.
package rv32i_pkg;

    // FETCH must stay at 4'd0: it is the reset state and the state_dbg reset value.
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEMADR    = 4'd2,
        MEMRD     = 4'd3,
        MEMWB     = 4'd4,
        MEMWR     = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        EXEC_U    = 4'd8,
        ALUWB     = 4'd9,
        BRANCH    = 4'd10,
        EXEC_JALR = 4'd11,
        JUMP      = 4'd12,
        ILLEGAL   = 4'd13
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_UPPER = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_PC     = 2'b10;

endpackage

// File: rtl/rv32i_branch_eval.sv
// Branch condition evaluator: funct3 plus ALU compare flags -> taken.
// Latency: combinational. Backpressure: none.
// Ports: funct3, alu_zero/alu_lt/alu_ltu flags in; taken out (0 for undefined funct3).
module rv32i_branch_eval
    import rv32i_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = alu_zero;
            F3_BNE:  taken = !alu_zero;
            F3_BLT:  taken = alu_lt;
            F3_BGE:  taken = !alu_lt;
            F3_BLTU: taken = alu_ltu;
            F3_BGEU: taken = !alu_ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Moore control FSM sequencing the shared ALU through fetch/decode/execute/mem/writeback.
// Latency: 3 (branch, JAL) to 5 (load) cycles per instruction, +1 per memory wait cycle.
// Backpressure: FETCH/MEMRD/MEMWR hold mem_req and address/write selects until mem_ready.
// Ports: clk/rst; opcode/funct3 from the IR; alu_zero/lt/ltu flags; mem_ready handshake in;
//        memory request, IR/PC load enables, ALU operand/op selects, writeback selects,
//        sticky illegal flag and state_dbg out.
module rv32i_multicycle_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [3:0] RESET_STATE_ENC = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_sel,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    state_t state_q;
    state_t state_d;
    logic   br_taken;

    rv32i_branch_eval u_branch_eval (
        .funct3   (funct3),
        .alu_zero (alu_zero),
        .alu_lt   (alu_lt),
        .alu_ltu  (alu_ltu),
        .taken    (br_taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= state_t'(RESET_STATE_ENC);
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RS2;
        alu_op       = ALU_ADD;
        result_sel   = RES_ALUOUT;
        reg_write    = 1'b0;
        illegal      = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                // Gated by rst so a held reset never loads IR/PC from a stray mem_ready.
                ir_write  = mem_ready && !rst;
                pc_write  = mem_ready && !rst;
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // Precompute old_pc + imm into alu_out for branch/JAL targets.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                case (opcode)
                    OPC_LOAD,
                    OPC_STORE:  state_d = MEMADR;
                    OPC_OP:     state_d = EXEC_R;
                    OPC_OPIMM:  state_d = EXEC_I;
                    OPC_BRANCH: state_d = (funct3 == 3'b010 || funct3 == 3'b011)
                                          ? ILLEGAL : BRANCH;
                    OPC_JAL:    state_d = JUMP;
                    OPC_JALR:   state_d = EXEC_JALR;
                    OPC_LUI,
                    OPC_AUIPC:  state_d = EXEC_U;
                    OPC_FENCE,
                    OPC_SYSTEM: state_d = FETCH;
                    default:    state_d = ILLEGAL;
                endcase
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                state_d   = (opcode == OPC_STORE) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                result_sel = RES_MEM;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end
            end
            EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALU_FUNCT;
                state_d   = ALUWB;
            end
            EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNCT;
                state_d   = ALUWB;
            end
            EXEC_U: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_UPPER;
                state_d   = ALUWB;
            end
            ALUWB: begin
                result_sel = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                // Compare rs1 - rs2 this cycle; target already sits in alu_out.
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALU_SUB;
                pc_src    = 1'b1;
                pc_write  = br_taken;
                state_d   = FETCH;
            end
            EXEC_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                state_d   = JUMP;
            end
            JUMP: begin
                // PC still holds old_pc + 4 here, which is the link value for rd.
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                result_sel = RES_PC;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            ILLEGAL: begin
                illegal = 1'b1;
                state_d = ILLEGAL;
            end
            default: begin
                state_d = ILLEGAL;
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed bench for rv32i_multicycle_ctrl: per-cycle expected output vectors are
// queued as each cycle's stimulus is applied and compared at the following negedge.
// Covers reset, every instruction class, memory wait states, branch outcomes, illegal, mid-op reset.
module tb_rv32i_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       mreq;
        logic       mwe;
        logic       masel;
        logic       irw;
        logic       pcw;
        logic       pcs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] aop;
        logic [1:0] rsel;
        logic       rw;
        logic       ill;
    } exp_t;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                           S_MEMRD = 4'd3, S_MEMWB = 4'd4, S_MEMWR = 4'd5,
                           S_EXEC_R = 4'd6, S_EXEC_I = 4'd7, S_EXEC_U = 4'd8,
                           S_ALUWB = 4'd9, S_BRANCH = 4'd10, S_EXEC_JALR = 4'd11,
                           S_JUMP = 4'd12, S_ILLEGAL = 4'd13;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alu_zero, alu_lt, alu_ltu, mem_ready;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_sel;
    logic       reg_write, illegal;
    logic [3:0] state_dbg;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    rv32i_multicycle_ctrl #(.RESET_STATE_ENC(4'd0)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct3       (funct3),
        .alu_zero     (alu_zero),
        .alu_lt       (alu_lt),
        .alu_ltu      (alu_ltu),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .result_sel   (result_sel),
        .reg_write    (reg_write),
        .illegal      (illegal),
        .state_dbg    (state_dbg)
    );

    // Expected output vectors per state, written straight from the state table.
    function automatic exp_t ex(input logic [3:0] st, input logic [5:0] ctl,
                                input logic [1:0] sa, input logic [1:0] sb,
                                input logic [1:0] aop, input logic [1:0] rsel,
                                input logic rw, input logic ill);
        return {st, ctl, sa, sb, aop, rsel, rw, ill};
    endfunction
    // ctl bits: mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src
    function automatic exp_t e_fetch(input logic ld);
        return ex(S_FETCH, {1'b1, 2'b00, ld, ld, 1'b0}, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic exp_t e_decode();
        return ex(S_DECODE, 6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic exp_t e_memadr();
        return ex(S_MEMADR, 6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic exp_t e_memrd();
        return ex(S_MEMRD, 6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic exp_t e_memwb();
        return ex(S_MEMWB, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0);
    endfunction
    function automatic exp_t e_memwr();
        return ex(S_MEMWR, 6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic exp_t e_exec_r();
        return ex(S_EXEC_R, 6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    endfunction
    function automatic exp_t e_exec_i();
        return ex(S_EXEC_I, 6'b000000, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0);
    endfunction
    function automatic exp_t e_exec_u();
        return ex(S_EXEC_U, 6'b000000, 2'b01, 2'b01, 2'b11, 2'b00, 0, 0);
    endfunction
    function automatic exp_t e_aluwb();
        return ex(S_ALUWB, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
    endfunction
    function automatic exp_t e_branch(input logic tk);
        return ex(S_BRANCH, {4'b0000, tk, 1'b1}, 2'b10, 2'b00, 2'b01, 2'b00, 0, 0);
    endfunction
    function automatic exp_t e_jalr();
        return ex(S_EXEC_JALR, 6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic exp_t e_jump();
        return ex(S_JUMP, 6'b000011, 2'b00, 2'b00, 2'b00, 2'b10, 1, 0);
    endfunction
    function automatic exp_t e_illegal();
        return ex(S_ILLEGAL, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
    endfunction

    // One clock cycle: apply mem_ready, queue the expectation, compare at negedge.
    task automatic step(input exp_t e, input logic rdy, input string name);
        exp_t got;
        exp_t want;
        mem_ready = rdy;
        sb_q.push_back(e);
        @(negedge clk);
        got = {state_dbg, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, result_sel, reg_write, illegal};
        want = sb_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got state=%0d vec=%05h, expected state=%0d vec=%05h",
                     name, got.st, got, want.st, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(e_fetch(1'b0), 1'b1, "reset_hold_rdy1");
        step(e_fetch(1'b0), 1'b1, "reset_hold_rdy1_b");
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        opcode = 7'b0110011; funct3 = 3'b000;
        step(e_fetch(1'b1), 1'b1, "add_fetch");
        step(e_decode(),    1'b1, "add_decode");
        step(e_exec_r(),    1'b1, "add_exec_r");
        step(e_aluwb(),     1'b1, "add_aluwb");
        step(e_fetch(1'b0), 1'b0, "add_back_fetch");
    endtask

    task automatic test_itype_utype();
        opcode = 7'b0010011;
        step(e_fetch(1'b1), 1'b1, "addi_fetch");
        step(e_decode(),    1'b0, "addi_decode");
        step(e_exec_i(),    1'b0, "addi_exec_i");
        step(e_aluwb(),     1'b0, "addi_aluwb");
        opcode = 7'b0010111;
        step(e_fetch(1'b1), 1'b1, "auipc_fetch");
        step(e_decode(),    1'b1, "auipc_decode");
        step(e_exec_u(),    1'b1, "auipc_exec_u");
        step(e_aluwb(),     1'b1, "auipc_aluwb");
        step(e_fetch(1'b0), 1'b0, "auipc_back_fetch");
    endtask

    task automatic test_load_wait();
        opcode = 7'b0000011; funct3 = 3'b010;
        step(e_fetch(1'b1), 1'b1, "lw_fetch");
        step(e_decode(),    1'b1, "lw_decode");
        step(e_memadr(),    1'b1, "lw_memadr");
        for (int i = 0; i < 3; i++) step(e_memrd(), 1'b0, "lw_memrd_wait");
        step(e_memrd(),     1'b1, "lw_memrd_done");
        step(e_memwb(),     1'b1, "lw_memwb");
        step(e_fetch(1'b0), 1'b0, "lw_back_fetch");
    endtask

    task automatic test_store();
        opcode = 7'b0100011;
        step(e_fetch(1'b0), 1'b0, "sw_fetch_wait");
        step(e_fetch(1'b1), 1'b1, "sw_fetch");
        step(e_decode(),    1'b0, "sw_decode");
        step(e_memadr(),    1'b0, "sw_memadr");
        step(e_memwr(),     1'b0, "sw_memwr_wait");
        step(e_memwr(),     1'b1, "sw_memwr_done");
        step(e_fetch(1'b0), 1'b0, "sw_back_fetch");
    endtask

    task automatic test_branches();
        logic [2:0] f3_t [8] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b111};
        logic [2:0] flg_t[8] = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b010, 3'b001, 3'b001, 3'b000};
        logic       tk_t [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        opcode = 7'b1100011;
        for (int i = 0; i < 8; i++) begin
            funct3 = f3_t[i];
            {alu_zero, alu_lt, alu_ltu} = flg_t[i];
            step(e_fetch(1'b1),     1'b1, $sformatf("br%0d_fetch", i));
            step(e_decode(),        1'b1, $sformatf("br%0d_decode", i));
            step(e_branch(tk_t[i]), 1'b1, $sformatf("br%0d_branch", i));
        end
        {alu_zero, alu_lt, alu_ltu} = 3'b000;
        step(e_fetch(1'b0), 1'b0, "br_back_fetch");
    endtask

    task automatic test_jumps();
        opcode = 7'b1101111;
        step(e_fetch(1'b1), 1'b1, "jal_fetch");
        step(e_decode(),    1'b1, "jal_decode");
        step(e_jump(),      1'b1, "jal_jump");
        opcode = 7'b1100111; funct3 = 3'b000;
        step(e_fetch(1'b1), 1'b1, "jalr_fetch");
        step(e_decode(),    1'b1, "jalr_decode");
        step(e_jalr(),      1'b1, "jalr_exec");
        step(e_jump(),      1'b1, "jalr_jump");
        opcode = 7'b1110011;
        step(e_fetch(1'b1), 1'b1, "ecall_fetch");
        step(e_decode(),    1'b1, "ecall_decode");
        step(e_fetch(1'b0), 1'b0, "ecall_nop_fetch");
    endtask

    task automatic test_illegal();
        opcode = 7'b0000000;
        step(e_fetch(1'b1), 1'b1, "ill_fetch");
        step(e_decode(),    1'b1, "ill_decode");
        for (int i = 0; i < 10; i++) step(e_illegal(), 1'b1, "ill_stuck");
        rst = 1'b1;
        step(e_illegal(), 1'b0, "ill_rst_pre_edge");
        rst = 1'b0;
        step(e_fetch(1'b0), 1'b0, "ill_cleared");
        // Undefined branch funct3 must also trap.
        opcode = 7'b1100011; funct3 = 3'b011;
        step(e_fetch(1'b1), 1'b1, "ill_br_fetch");
        step(e_decode(),    1'b1, "ill_br_decode");
        step(e_illegal(),   1'b1, "ill_br_trap");
        rst = 1'b1;
        step(e_illegal(), 1'b0, "ill_br_rst");
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        opcode = 7'b0100011;
        step(e_fetch(1'b1), 1'b1, "rst_sw_fetch");
        step(e_decode(),    1'b0, "rst_sw_decode");
        step(e_memadr(),    1'b0, "rst_sw_memadr");
        step(e_memwr(),     1'b0, "rst_sw_memwr");
        rst = 1'b1;
        step(e_memwr(), 1'b0, "rst_sw_memwr_rst");
        rst = 1'b0;
        step(e_fetch(1'b0), 1'b0, "rst_sw_fetch_after");
        step(e_fetch(1'b1), 1'b1, "rst_sw_refetch");
        step(e_decode(),    1'b0, "rst_sw_redecode");
    endtask

    initial begin
        rst = 1'b1; opcode = '0; funct3 = '0;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_rtype();
        test_itype_utype();
        test_load_wait();
        test_store();
        test_branches();
        test_jumps();
        test_illegal();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
Name: rv32i_multicycle_ctrl

Overview:
- Moore-style control FSM for the multi-cycle RV32I core.
- Sequences the single shared ALU through fetch, decode, execute, memory and writeback steps.
- Drives alu_op into the existing ALU decoder and steers the PC, instruction register and memory handshake.
- One instruction in flight; no pipelining.

Parameters:
- RESET_STATE_ENC, 4'd0, encoding of FETCH; sets the reset state and the state_dbg reset value.

Ports:
- clk  in  1  core clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instruction-register opcode field
- funct3  in  3  instruction-register funct3 field
- alu_zero  in  1  ALU result == 0
- alu_lt  in  1  signed rs1 < rs2
- alu_ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- mem_addr_sel  out  1  0 = PC, 1 = alu_out register
- ir_write  out  1  load the instruction register and old_pc
- pc_write  out  1  load the PC
- pc_src  out  1  0 = live ALU result, 1 = alu_out register
- alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
- alu_op  out  2  00 = add, 01 = sub, 10 = funct decode, 11 = LUI/AUIPC
- result_sel  out  2  00 = alu_out, 01 = mem data, 10 = PC
- reg_write  out  1  register-file write enable
- illegal  out  1  sticky illegal-instruction flag
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: rst sampled high puts the FSM in FETCH on that edge, including mid-transaction. Any pending mem_req is abandoned.
- In every state, outputs not listed for that state are 0.
- While rst is held, all outputs are 0 except state_dbg = RESET_STATE_ENC and the fixed FETCH outputs (mem_req = 1, alu_src_b = 10).
- illegal resets to 0.

Memory handshake:
- mem_req, mem_we and mem_addr_sel stay stable until a cycle with mem_ready = 1; the FSM leaves the state on that edge.
- mem_ready is ignored while mem_req = 0.

States and transitions:
- FETCH: mem_req = 1, addr = PC, alu_src_a = 00, alu_src_b = 10, alu_op = 00.
  - On mem_ready: ir_write = 1, pc_write = 1, pc_src = 0 (PC <= PC + 4), go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a = 01, alu_src_b = 01, alu_op = 00, so alu_out <= old_pc + imm (branch/JAL target). Next state by opcode:
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH (funct3 010/011 -> ILLEGAL)
  - 1101111 -> JUMP
  - 1100111 -> EXEC_JALR
  - 0110111 / 0010111 -> EXEC_U
  - 0001111 / 1110011 -> FETCH (treated as NOP)
  - anything else -> ILLEGAL
- MEMADR: alu_src_a = 10, alu_src_b = 01, alu_op = 00. Loads -> MEMRD, stores -> MEMWR.
- MEMRD: mem_req = 1, mem_addr_sel = 1. On mem_ready -> MEMWB.
- MEMWB: result_sel = 01, reg_write = 1 -> FETCH.
- MEMWR: mem_req = 1, mem_we = 1, mem_addr_sel = 1. On mem_ready -> FETCH.
- EXEC_R: alu_src_a = 10, alu_src_b = 00, alu_op = 10 -> ALUWB.
- EXEC_I: alu_src_a = 10, alu_src_b = 01, alu_op = 10 -> ALUWB.
- EXEC_U: alu_src_a = 01, alu_src_b = 01, alu_op = 11 -> ALUWB.
- ALUWB: result_sel = 00, reg_write = 1 -> FETCH.
- BRANCH: alu_src_a = 10, alu_src_b = 00, alu_op = 01, pc_src = 1. pc_write = taken, then FETCH. taken by funct3:
  - 000: zero
  - 001: !zero
  - 100: lt
  - 101: !lt
  - 110: ltu
  - 111: !ltu
- EXEC_JALR: alu_src_a = 10, alu_src_b = 01, alu_op = 00 -> JUMP.
- JUMP: pc_write = 1, pc_src = 1, result_sel = 10, reg_write = 1 (rd <= pre-update PC = old_pc + 4) -> FETCH.
- ILLEGAL: illegal = 1, no further requests. Terminal until rst.

Latency with zero-wait memory (each wait cycle adds 1):
- R/I/U-type: 4 cycles
- load: 5 cycles
- store: 4 cycles
- branch: 3 cycles
- JAL: 3 cycles
- JALR: 4 cycles

Output timing:
- All outputs are registered-state decodes.
- pc_write in FETCH and BRANCH additionally depends on mem_ready or the flags combinationally.

Decomposition:
- Shared package rv32i_pkg holds:
  - state enum (4-bit): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, EXEC_U, ALUWB, BRANCH, EXEC_JALR, JUMP, ILLEGAL
  - opcode constants
  - alu_op, alu_src_a, alu_src_b and result_sel encodings
- Optional sub-module rv32i_branch_eval: combinational funct3 + flags -> taken.

Test Plan:
- add x3,x1,x2 (opcode 0110011), mem_ready always 1:
  - states FETCH, DECODE, EXEC_R, ALUWB
  - alu_op = 10 in EXEC_R; reg_write = 1 only in ALUWB; back in FETCH on cycle 5.
- lw, mem_ready low 3 cycles in MEMRD:
  - mem_req, mem_addr_sel = 1 held 4 cycles
  - MEMWB with result_sel = 01, reg_write = 1; total 8 cycles.
- beq, alu_zero = 1 then a second beq with alu_zero = 0:
  - first: pc_write = 1, pc_src = 1 in BRANCH
  - second: pc_write = 0; both return to FETCH after 3 cycles.
- jalr:
  - EXEC_JALR with alu_src_a = 10, alu_src_b = 01
  - JUMP with pc_write = 1, pc_src = 1, reg_write = 1, result_sel = 10.
- opcode 0000000:
  - DECODE -> ILLEGAL, illegal = 1, mem_req stays 0 for 10 cycles
  - rst pulse -> FETCH, illegal = 0.
- rst asserted during MEMWR with mem_ready = 0:
  - next edge: state_dbg = 0, mem_we = 0, mem_req re-asserts for FETCH only after rst deasserts.
